// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a writable {period, duration} note table and
// drives the period/compare/reset inputs of a pwm tone generator.
// Each note is held for dur * TICK_DIV clocks, followed by an optional silent
// gap of GAP_TICKS * TICK_DIV clocks. The generator is held in reset outside PLAY
// so every note starts phase-aligned.
// Optional feature macro: TONE_SEQ_LOOP_EN adds the 'loop' input, which restarts
// playback at entry 0 instead of finishing.
module tone_sequencer #(
   parameter int MAX_WAVE   = 24,
   parameter int DEPTH_LOG2 = 5,
   parameter int DUR_W      = 8,
   parameter int TICK_DIV   = 50000,
   parameter int GAP_TICKS  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [MAX_WAVE-1:0]   wr_period,
   input  logic [DUR_W-1:0]      wr_dur,
`ifdef TONE_SEQ_LOOP_EN
   input  logic                  loop,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [DEPTH_LOG2-1:0] note_idx,
   output logic [MAX_WAVE-1:0]   period,
   output logic [MAX_WAVE-1:0]   compare,
   output logic                  pwm_rst
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0]      PRE_ONE  = PRE_W'(1);
   localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(GAP_TICKS);
   localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
   localparam logic [DUR_W-1:0]      DUR_ONE  = DUR_W'(1);
   localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] IDX_LAST = DEPTH_LOG2'(DEPTH - 1);
   localparam logic [MAX_WAVE-1:0]   CMP_OFF  = {MAX_WAVE{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_PLAY  = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [DUR_W-1:0]        dur_q, dur_d;
   logic [PRE_W-1:0]        pre_q, pre_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [MAX_WAVE-1:0]     period_q, period_d;
   logic [MAX_WAVE-1:0]     compare_q, compare_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pwm_rst_q, pwm_rst_d;

   logic [MAX_WAVE-1:0]     per_tbl_q [DEPTH];
   logic [DUR_W-1:0]        dur_tbl_q [DEPTH];

   logic                    loop_s;
   logic                    tick_s;
   logic                    adv_s;
   logic                    go_done_s;
   logic [MAX_WAVE-1:0]     fetch_per_s;
   logic [DUR_W-1:0]        fetch_dur_s;

`ifdef TONE_SEQ_LOOP_EN
   assign loop_s = loop;
`else
   assign loop_s = 1'b0;
`endif

   // Reads see the table as it was before any same-cycle write.
   assign fetch_per_s = per_tbl_q[idx_q];
   assign fetch_dur_s = dur_tbl_q[idx_q];
   assign tick_s      = (pre_q == PRE_LAST);

   // Note table: cleared to all end markers on reset, writable in every state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            per_tbl_q[i] <= '0;
            dur_tbl_q[i] <= '0;
         end
      end else if (wr_en) begin
         per_tbl_q[wr_addr] <= wr_period;
         dur_tbl_q[wr_addr] <= wr_dur;
      end else begin
         per_tbl_q[wr_addr] <= per_tbl_q[wr_addr];
         dur_tbl_q[wr_addr] <= dur_tbl_q[wr_addr];
      end
   end

   // Next-state and next-output logic; outputs are derived from the next state
   // so they are registered alongside it.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      dur_d     = dur_q;
      pre_d     = pre_q;
      gap_d     = gap_q;
      period_d  = period_q;
      compare_d = compare_q;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      pwm_rst_d = 1'b1;
      adv_s     = 1'b0;
      go_done_s = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (fetch_dur_s == '0) begin
               go_done_s = 1'b1;
            end else begin
               state_d  = S_PLAY;
               period_d = fetch_per_s;
               // A rest keeps the pwm output low by never reaching compare.
               if (fetch_per_s == '0) begin
                  compare_d = CMP_OFF;
               end else begin
                  compare_d = fetch_per_s >> 1;
               end
               dur_d = fetch_dur_s;
               pre_d = '0;
            end
         end
         S_PLAY: begin
            if (tick_s) begin
               pre_d = '0;
               if (dur_q == DUR_ONE) begin
                  dur_d = '0;
                  if (GAP_TICKS > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LOAD;
                  end else begin
                     adv_s = 1'b1;
                  end
               end else begin
                  dur_d = dur_q - DUR_ONE;
               end
            end else begin
               pre_d = pre_q + PRE_ONE;
            end
         end
         S_GAP: begin
            if (tick_s) begin
               pre_d = '0;
               if (gap_q <= GAP_ONE) begin
                  adv_s = 1'b1;
               end else begin
                  gap_d = gap_q - GAP_ONE;
               end
            end else begin
               pre_d = pre_q + PRE_ONE;
            end
         end
         S_DONE: begin
            // done_q low here means DONE was entered with loop set.
            if (!done_q || start) begin
               state_d = S_FETCH;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (adv_s) begin
         if (idx_q == IDX_LAST) begin
            go_done_s = 1'b1;
         end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_FETCH;
         end
      end else begin
         idx_d = idx_d;
      end

      if (go_done_s) begin
         state_d = S_DONE;
         done_d  = ~loop_s;
      end else begin
         done_d = 1'b0;
      end

      // Silence outside PLAY; the generator runs only while a note plays.
      if (state_d == S_PLAY) begin
         pwm_rst_d = 1'b0;
      end else if (state_d == S_GAP) begin
         compare_d = CMP_OFF;
      end else begin
         period_d  = '0;
         compare_d = CMP_OFF;
      end

      busy_d = (state_d == S_FETCH) || (state_d == S_PLAY) || (state_d == S_GAP) ||
               ((state_d == S_DONE) && !done_d);

      // Abort has priority over everything, including a same-cycle start.
      if (stop) begin
         state_d   = S_IDLE;
         idx_d     = '0;
         dur_d     = '0;
         pre_d     = '0;
         gap_d     = '0;
         period_d  = '0;
         compare_d = CMP_OFF;
         done_d    = 1'b0;
         busy_d    = 1'b0;
         pwm_rst_d = 1'b1;
      end else begin
         state_d = state_d;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         dur_q     <= '0;
         pre_q     <= '0;
         gap_q     <= '0;
         period_q  <= '0;
         compare_q <= CMP_OFF;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pwm_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         dur_q     <= dur_d;
         pre_q     <= pre_d;
         gap_q     <= gap_d;
         period_q  <= period_d;
         compare_q <= compare_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pwm_rst_q <= pwm_rst_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign note_idx = idx_q;
   assign period   = period_q;
   assign compare  = compare_q;
   assign pwm_rst  = pwm_rst_q;

endmodule
